zigbee_chip_spreader: RTL and testbench

// - IEEE 802.15.4 (2.4 GHz) DSSS spreader between the TX input FIFO and the O-QPSK modulator/coder.
// - Pops 4-bit symbols from the FIFO and maps each to its 32-chip PN sequence.
// - Emits chips as 16 I/Q pairs (I = even chips, Q = odd chips), each pair held CHIP_DIV clocks.
// - Chains consecutive symbols without gaps while the FIFO holds data.

---
 rtl/zigbee_chip_spreader.sv | 99 +++++++++
 tb/tb_zigbee_chip_spreader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/zigbee_chip_spreader.sv
// zigbee_chip_spreader: 802.15.4 DSSS spreader, FIFO symbols to 32-chip PN sequences as I/Q pairs
module zigbee_chip_spreader #(
  parameter int CHIP_DIV = 4
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic [3:0] inData,
  input  logic       inEmpty,
  output logic       outReadEnable,
  output logic       outChipI,
  output logic       outChipQ,
  output logic       outValid,
  output logic       outSymbolDone,
  output logic       outBusy
);
  localparam int DW = CHIP_DIV > 1 ? $clog2(CHIP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CHIP_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);
  localparam logic [31:0] SYM0 = 32'hD9C3_522E;
  typedef enum logic [1:0] {IDLE, READ, LOAD, SPREAD} state_t;
  state_t state, stateNext;
  logic [3:0] pair, pairNext, nextSym, nextSymNext;
  logic [DW-1:0] div, divNext;
  logic [31:0] chips, chipsNext;
  logic pend, pendNext, renNext, doneNext;
  // Symbols 8..15 reuse 0..7 with the odd (Q) chips inverted.
  function automatic logic [31:0] chipWord(input logic [3:0] sym);
    logic [63:0] rot;
    rot = {SYM0, SYM0} >> {sym[2:0], 2'b00};
    return rot[31:0] ^ (sym[3] ? 32'h5555_5555 : 32'h0);
  endfunction
  always_comb begin
    stateNext = state;
    pairNext = pair;
    divNext = div;
    chipsNext = chips;
    nextSymNext = nextSym;
    pendNext = pend;
    renNext = 1'b0;
    doneNext = 1'b0;
    case (state)
      IDLE: begin
        stateNext = inEmpty ? IDLE : READ;
        renNext = !inEmpty;
      end
      READ: stateNext = LOAD;
      LOAD: begin
        stateNext = SPREAD;
        chipsNext = chipWord(inData);
        pairNext = 4'd0;
        divNext = '0;
      end
      SPREAD: begin
        divNext = div + 1'b1;
        nextSymNext = (pend && pair == 4'd15 && div == DIV_ONE) ? inData : nextSym;
        if (div == DIV_LAST) begin
          divNext = '0;
          pairNext = pair + 4'd1;
          chipsNext = chips << 2;
          renNext = pair == 4'd14 && !inEmpty;
          pendNext = pair == 4'd14 ? !inEmpty : pair == 4'd15 ? 1'b0 : pend;
          if (pair == 4'd15) begin
            stateNext = pend ? SPREAD : IDLE;
            chipsNext = pend ? chipWord(nextSym) : '0;
          end
        end
        doneNext = pairNext == 4'd15 && divNext == DIV_LAST;
      end
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      state <= IDLE;
      pair <= '0;
      div <= '0;
      chips <= '0;
      nextSym <= '0;
      pend <= 1'b0;
      outReadEnable <= 1'b0;
      outSymbolDone <= 1'b0;
      outValid <= 1'b0;
      outBusy <= 1'b0;
    end else begin
      state <= stateNext;
      pair <= pairNext;
      div <= divNext;
      chips <= chipsNext;
      nextSym <= nextSymNext;
      pend <= pendNext;
      outReadEnable <= renNext;
      outSymbolDone <= doneNext;
      outValid <= stateNext == SPREAD;
      outBusy <= stateNext != IDLE;
    end
  end
  assign outChipI = chips[31];
  assign outChipQ = chips[30];
endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// tb_zigbee_chip_spreader: directed checks of chip mapping, chaining, prefetch and reset abort
module tb_zigbee_chip_spreader;
  localparam int DIV = 4;
  logic inClock = 1'b0;
  logic inReset = 1'b0;
  logic [3:0] inData = 4'h0;
  logic inEmpty;
  logic outReadEnable, outChipI, outChipQ, outValid, outSymbolDone, outBusy;
  logic [3:0] fifoMem [0:15];
  logic [3:0] wrPtr = 4'd0;
  logic [3:0] rdPtr = 4'd0;
  logic forceEmpty = 1'b1;
  int pops = 0;
  int checks = 0;
  int errors = 0;
  int lastWait = 0;
  int lastRen = 0;

  zigbee_chip_spreader #(.CHIP_DIV(DIV)) dut (
    .inClock(inClock), .inReset(inReset), .inData(inData), .inEmpty(inEmpty),
    .outReadEnable(outReadEnable), .outChipI(outChipI), .outChipQ(outChipQ),
    .outValid(outValid), .outSymbolDone(outSymbolDone), .outBusy(outBusy)
  );

  assign inEmpty = forceEmpty | (wrPtr == rdPtr);
  always #5 inClock = ~inClock;

  // Registered-read FIFO: data appears the cycle after the pop request.
  always @(posedge inClock) begin
    if (inReset && outReadEnable) begin
      inData <= fifoMem[rdPtr];
      rdPtr <= rdPtr + 4'd1;
      pops <= pops + 1;
    end
  end

  task automatic push(input logic [3:0] s);
    fifoMem[wrPtr] = s;
    wrPtr = wrPtr + 4'd1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic runSymbol(input logic [31:0] exp, input string tag);
    logic [31:0] w;
    int doneHits, badCycles;
    w = '0;
    doneHits = 0;
    badCycles = 0;
    lastRen = 0;
    @(negedge inClock);
    lastWait = 0;
    while (outValid !== 1'b1 && lastWait < 20) begin
      @(negedge inClock);
      lastWait++;
    end
    check({tag, " valid"}, {31'd0, outValid}, 32'd1);
    for (int n = 0; n < 16; n++) begin
      for (int d = 0; d < DIV; d++) begin
        if (n != 0 || d != 0) @(negedge inClock);
        if (d == 0) begin
          w[31-2*n] = outChipI;
          w[30-2*n] = outChipQ;
        end else if (outChipI !== w[31-2*n] || outChipQ !== w[30-2*n]) badCycles++;
        if (outValid !== 1'b1) badCycles++;
        if (outSymbolDone === 1'b1) doneHits += (n == 15 && d == DIV - 1) ? 1 : 100;
        if (outReadEnable === 1'b1) lastRen += (n == 15 && d == 0) ? 1 : 100;
      end
    end
    check({tag, " chips"}, w, exp);
    check({tag, " done"}, doneHits, 32'd1);
    check({tag, " steady"}, badCycles, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    forceEmpty = 1'b0;
    push(4'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge inClock);
      check("T1 outputs", {26'd0, outReadEnable, outChipI, outChipQ, outValid, outSymbolDone, outBusy}, 32'd0);
    end
    check("T1 pops", pops, 32'd0);
    inReset = 1'b1;
    @(negedge inClock);
    check("T2 read", {29'd0, outReadEnable, outBusy, outValid}, 32'b110);
    @(negedge inClock);
    check("T2 load", {29'd0, outReadEnable, outBusy, outValid}, 32'b010);
    runSymbol(32'hD9C3_522E, "T2");
    check("T2 latency", lastWait, 32'd0);
    check("T2 ren", lastRen, 32'd0);
    @(negedge inClock);
    check("T2 idle", {30'd0, outValid, outBusy}, 32'd0);
    check("T2 pops", pops, 32'd1);

    push(4'h1);
    runSymbol(32'hED9C_3522, "T3a");
    @(negedge inClock);
    check("T3a idle", {30'd0, outValid, outBusy}, 32'd0);
    push(4'h9);
    runSymbol(32'hB8C9_6077, "T3b");
    @(negedge inClock);
    check("T3b idle", {30'd0, outValid, outBusy}, 32'd0);
    check("T3 pops", pops, 32'd3);

    push(4'h1);
    push(4'h4);
    push(4'h9);
    runSymbol(32'hED9C_3522, "T4a");
    check("T4a prefetch", lastRen, 32'd1);
    runSymbol(32'h522E_D9C3, "T4b");
    check("T4b gap", lastWait, 32'd0);
    check("T4b prefetch", lastRen, 32'd1);
    runSymbol(32'hB8C9_6077, "T4c");
    check("T4c gap", lastWait, 32'd0);
    check("T4c prefetch", lastRen, 32'd0);
    @(negedge inClock);
    check("T4 idle", {30'd0, outValid, outBusy}, 32'd0);
    check("T4 pops", pops, 32'd6);

    forceEmpty = 1'b1;
    push(4'h3);
    push(4'h5);
    @(negedge inClock);
    forceEmpty = 1'b0;
    @(negedge inClock);
    forceEmpty = 1'b1;
    fork
      runSymbol(32'h22ED_9C35, "T5");
      begin
        for (int t = 0; t < 20 && outValid !== 1'b1; t++) @(negedge inClock);
        for (int i = 0; i < 55; i++) begin
          forceEmpty = ~forceEmpty;
          @(negedge inClock);
        end
        forceEmpty = 1'b1;
      end
    join
    check("T5 ren", lastRen, 32'd0);
    @(negedge inClock);
    check("T5 idle", {30'd0, outValid, outBusy}, 32'd0);
    check("T5 pops", pops, 32'd7);

    push(4'h6);
    forceEmpty = 1'b0;
    for (int t = 0; t < 20 && outValid !== 1'b1; t++) @(negedge inClock);
    repeat (7 * DIV) @(negedge inClock);
    check("T6 pair7", {29'd0, outValid, outChipI, outChipQ}, 32'b110);
    #2 inReset = 1'b0;
    #1 check("T6 async", {26'd0, outReadEnable, outChipI, outChipQ, outValid, outSymbolDone, outBusy}, 32'd0);
    repeat (3) @(negedge inClock);
    check("T6 held", {26'd0, outReadEnable, outChipI, outChipQ, outValid, outSymbolDone, outBusy}, 32'd0);
    check("T6 pops held", pops, 32'd8);
    inReset = 1'b1;
    @(negedge inClock);
    check("T6 read", {29'd0, outReadEnable, outBusy, outValid}, 32'b110);
    @(negedge inClock);
    check("T6 load", {29'd0, outReadEnable, outBusy, outValid}, 32'b010);
    runSymbol(32'hC352_2ED9, "T6");
    check("T6 latency", lastWait, 32'd0);
    @(negedge inClock);
    check("T6 idle", {30'd0, outValid, outBusy}, 32'd0);
    check("T6 pops", pops, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
